// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: owns the PC, runs the imem request/ready
// handshake, selects the next PC and traps on misaligned targets.
module pc_fetch_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] pc_target,
  input  logic [1:0]       pc_src,
  input  logic             stall,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             instr_valid,
  output logic             misalign_err,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] sel_pc;
  logic             misaligned;
  logic             fetch_done;

  // jalr clears bit 0 only; bit 1 may still be set and is caught as misaligned.
  always_comb begin
    sel_pc = pc_reg;
    case (pc_src)
      2'b00:   sel_pc = pc_plus4;
      2'b01:   sel_pc = pc_target;
      2'b10:   sel_pc = {pc_target[WIDTH-1:1], 1'b0};
      default: sel_pc = pc_reg;
    endcase
  end

  assign misaligned = |sel_pc[1:0];
  assign imem_req   = (state_reg == FETCH);
  assign fetch_done = imem_req & imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      count_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    valid_next = 1'b0;
    err_next   = err_reg;
    case (state_reg)
      BOOT: state_next = FETCH;
      FETCH: begin
        if (fetch_done) begin
          count_next = count_reg + WIDTH'(1);
          valid_next = 1'b1;
          // A stall defers the PC decision to HOLD, even for a bad target.
          if (stall) begin
            state_next = HOLD;
          end else if (misaligned) begin
            err_next   = 1'b1;
            state_next = TRAP;
          end else begin
            pc_next = sel_pc;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if (misaligned) begin
            err_next   = 1'b1;
            state_next = TRAP;
          end else begin
            pc_next    = sel_pc;
            state_next = FETCH;
          end
        end
      end
      default: err_next = 1'b1;
    endcase
  end

  assign pc           = pc_reg;
  assign fetch_count  = count_reg;
  assign instr_valid  = valid_reg;
  assign misalign_err = err_reg;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and fetch sequencer for the 32-bit single-cycle RISC-V core. It holds the current PC and drives it to the PC-increment adder and the instruction-memory address. It takes the adder's sum back as the sequential next PC and selects between sequential, branch and jalr targets. It runs a small request/ready handshake with instruction memory and supports stall and misaligned-target trapping.

## Interface
- WIDTH, 32, datapath width of PC and targets.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pc  output  WIDTH  current PC; drives adder input a (b tied to 4) and imem address.
- pc_plus4  input  WIDTH  adder output y, combinational function of pc.
- pc_target  input  WIDTH  branch/jal target (pc + imm) or jalr target (rs1 + imm).
- pc_src  input  2  next-PC select: 00 sequential, 01 branch/jal, 10 jalr, 11 hold.
- stall  input  1  freeze PC update after the current fetch completes.
- imem_req  output  1  fetch request to instruction memory.
- imem_ready  input  1  memory accepts/returns instruction this cycle.
- instr_valid  output  1  one-cycle pulse: instruction for the old pc is on imem data.
- misalign_err  output  1  sticky trap flag: misaligned next PC was selected.
- fetch_count  output  WIDTH  number of completed fetches; wraps modulo 2^WIDTH.

## Operation
- States: BOOT, FETCH, HOLD, TRAP. Reset forces BOOT asynchronously.
- Reset values: pc=RESET_PC, imem_req=0, instr_valid=0, misalign_err=0, fetch_count=0.
- BOOT: imem_req=0; unconditionally moves to FETCH on the next edge.
- FETCH: imem_req=1.
  - fetch_done = imem_req & imem_ready.
  - Without fetch_done: remain in FETCH; pc is held; the request stays asserted.
- next_pc:
  - 00: pc_plus4.
  - 01: pc_target.
  - 10: {pc_target[WIDTH-1:1],1'b0}.
  - 11: pc.
- Alignment: next_pc[1:0] != 2'b00 is misaligned.
- On fetch_done:
  - fetch_count increments and instr_valid is high the next cycle.
  - stall=0, aligned: pc <= next_pc; stay in FETCH.
  - stall=1: pc is unchanged; go to HOLD.
  - stall=0, misaligned: pc is unchanged; misalign_err <= 1; go to TRAP.
- HOLD: imem_req=0.
  - While stall=1: remain in HOLD.
  - When stall=0: evaluate next_pc from current pc_src/pc_target. If aligned, pc <= next_pc and go to FETCH. If misaligned, go to TRAP.
- TRAP: imem_req=0; pc frozen; misalign_err=1. Exited only by reset.
- pc_src=11 with stall=0 refetches the same pc each fetch_done. fetch_count still increments.
- The adder is not checked for overflow: pc_plus4 wraps naturally at 2^WIDTH.

## Timing
- All state, pc, fetch_count, instr_valid and misalign_err are registered. imem_req is decoded from state (Moore).
- First request: imem_req rises one cycle after reset deasserts (BOOT -> FETCH).
- Zero-wait memory (imem_ready tied 1): one fetch per cycle.
  - pc advances every edge.
  - instr_valid is continuously high from the second FETCH cycle onward.
- Stall asserted in the fetch_done cycle:
  - pc holds; imem_req drops the next cycle.
  - The PC update occurs on the first edge with stall=0 in HOLD.
  - FETCH resumes the following cycle.
- stall asserted while no fetch_done is ignored until fetch_done.
- pc_src, pc_target and stall are sampled only on edges where an update is decided: fetch_done in FETCH, or stall=0 in HOLD.
- Reset mid-fetch: outputs take reset values immediately (asynchronously), and any in-flight request is abandoned. instr_valid is not asserted for it.
- fetch_count wraps from all-ones to 0 without side effects.

## Test plan
- Reset then imem_ready=1, pc_src=00 for 4 cycles -> pc = 0,4,8,12,16; fetch_count=4; instr_valid high from cycle 2.
- At pc=0x10, imem_ready=1, pc_src=01, pc_target=0x100 -> pc=0x100 next edge. At 0x100, pc_src=10, pc_target=0x203 -> pc=0x202? No: misaligned -> misalign_err=1, pc stays 0x100, state TRAP, imem_req=0 until reset.
- imem_ready low 3 cycles at pc=0x8 -> imem_req held high, pc stays 0x8, fetch_count unchanged. Then ready=1 -> pc=0xC.
- stall=1 on a fetch_done at pc=0x20 for 2 cycles with pc_src=01, pc_target=0x40 -> imem_req low 2 cycles, pc=0x20. On stall release, pc=0x40 and FETCH resumes.
- RESET_PC=0xFFFF_FFFC, pc_src=00, one fetch -> pc wraps to 0x0. Preset fetch_count near 2^32-1 via long run, or use WIDTH=8 -> count wraps to 0.
- Assert reset mid-FETCH with imem_ready=0 -> pc=RESET_PC, imem_req=0, misalign_err=0 in the same cycle. Restart matches scenario 1.
